// File: rtl/crc_frame_ctrl.sv
// Frame sequencer around a combinational CRC step: folds one WCODE-bit word per
// accepted beat into a running remainder and reports it over a result handshake.
module crc_frame_ctrl #(
  parameter int WCODE     = 4,
  parameter int WPOLY     = 3,
  parameter int MAX_WORDS = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic [WPOLY-1:0]                 i_poly,
  input  logic [WPOLY-2:0]                 i_seed,
  input  logic                             i_abort,
  input  logic [WCODE-1:0]                 i_data,
  input  logic                             i_valid,
  input  logic                             i_last,
  output logic                             o_ready,
  output logic [WPOLY-2:0]                 o_crc,
  output logic                             o_crc_valid,
  input  logic                             i_crc_ready,
  output logic [$clog2(MAX_WORDS+1)-1:0]   o_count,
  output logic                             o_busy,
  output logic                             o_err
);

  localparam int RW = WPOLY - 1;
  localparam int TW = WCODE + WPOLY - 1;
  localparam int CW = $clog2(MAX_WORDS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WPOLY-1:0] poly_q, poly_d;
  logic [RW-1:0]    crc_q, crc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic [TW-1:0]    step_t;
  logic [CW-1:0]    count_inc;
  logic             accept;
  logic             unused_step_hi;

  // Each set data bit d[i] folds in the polynomial aligned at bit i; the
  // decision uses the original word bits, never the partially reduced value.
  always_comb begin
    step_t = {i_data, crc_q};
    for (int i = 0; i < WCODE; i++) begin
      if (i_data[i]) begin
        step_t = step_t ^ (TW'(poly_q) << i);
      end
    end
  end
  assign unused_step_hi = ^step_t[TW-1:RW];

  assign count_inc = count_q + 1'b1;
  assign o_ready   = (state_q == S_RUN) && !i_abort;
  assign accept    = o_ready && i_valid;

  always_comb begin
    state_d = state_q;
    poly_d  = poly_q;
    crc_d   = crc_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          poly_d  = i_poly;
          crc_d   = i_seed;
          count_d = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          crc_d   = step_t[RW-1:0];
          count_d = count_inc;
          if (i_last) begin
            state_d = S_DONE;
          end else if (count_inc == CW'(MAX_WORDS)) begin
            // Truncated frame: report the remainder of the words taken so far.
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_abort || i_crc_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      poly_q  <= '0;
      crc_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      poly_q  <= poly_d;
      crc_q   <= crc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign o_crc       = crc_q;
  assign o_crc_valid = (state_q == S_DONE);
  assign o_count     = count_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_err       = err_q;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Randomized and directed bench for crc_frame_ctrl against a transaction-level
// reference built from the step definition (shift-and-xor over {d,c}).
module tb_crc_frame_ctrl;

  localparam int WCODE     = 4;
  localparam int WPOLY     = 3;
  localparam int MAX_WORDS = 16;
  localparam int CW        = $clog2(MAX_WORDS + 1);

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_start;
  logic [WPOLY-1:0] i_poly;
  logic [WPOLY-2:0] i_seed;
  logic             i_abort;
  logic [WCODE-1:0] i_data;
  logic             i_valid;
  logic             i_last;
  logic             o_ready;
  logic [WPOLY-2:0] o_crc;
  logic             o_crc_valid;
  logic             i_crc_ready;
  logic [CW-1:0]    o_count;
  logic             o_busy;
  logic             o_err;

  int total = 0;
  int bad   = 0;

  logic [WCODE-1:0] frame_w [MAX_WORDS];

  crc_frame_ctrl #(.WCODE(WCODE), .WPOLY(WPOLY), .MAX_WORDS(MAX_WORDS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_poly(i_poly),
    .i_seed(i_seed), .i_abort(i_abort), .i_data(i_data), .i_valid(i_valid),
    .i_last(i_last), .o_ready(o_ready), .o_crc(o_crc), .o_crc_valid(o_crc_valid),
    .i_crc_ready(i_crc_ready), .o_count(o_count), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Literal step: t={d,c}, p={g,0..}; xor p in for each set original d bit, shifting p right.
  function automatic logic [WPOLY-2:0] ref_step(input logic [WCODE-1:0] d,
                                                input logic [WPOLY-2:0] c,
                                                input logic [WPOLY-1:0] g);
    logic [WCODE+WPOLY-2:0] t;
    logic [WCODE+WPOLY-2:0] p;
    t = {d, c};
    p = {g, {(WCODE-1){1'b0}}};
    for (int i = WCODE - 1; i >= 0; i--) begin
      if (d[i]) t = t ^ p;
      p = p >> 1;
    end
    return t[WPOLY-2:0];
  endfunction

  task automatic do_start(input logic [WPOLY-2:0] seed);
    @(negedge i_clk);
    i_start = 1'b1;
    i_seed  = seed;
    i_poly  = 3'b111;
    @(negedge i_clk);
    i_start = 1'b0;
    check("start_ready", o_ready, 1);
    check("start_count", o_count, 0);
    check("start_err", o_err, 0);
  endtask

  // One whole frame from frame_w[0..n-1]; a frame without i_last must be MAX_WORDS long.
  task automatic run_frame(input logic [WPOLY-2:0] seed, input int n, input bit with_last,
                           input int gmin, input int gmax, input int hold,
                           output logic [WPOLY-2:0] crc_out);
    logic [WPOLY-2:0] c;
    int gaps;
    c = seed;
    do_start(seed);
    for (int k = 0; k < n; k++) begin
      gaps = int'($urandom_range(gmax, gmin));
      for (int g = 0; g < gaps; g++) begin
        i_valid = 1'b0;
        @(negedge i_clk);
        check("gap_count", o_count, k);
      end
      check("word_ready", o_ready, 1);
      i_valid = 1'b1;
      i_data  = frame_w[k];
      i_last  = with_last && (k == n - 1);
      @(negedge i_clk);
      c = ref_step(frame_w[k], c, 3'b111);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    check("done_valid", o_crc_valid, 1);
    check("done_crc", o_crc, c);
    check("done_count", o_count, n);
    check("done_err", o_err, !with_last);
    check("done_ready", o_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      check("hold_crc", o_crc, c);
      check("hold_valid", o_crc_valid, 1);
    end
    i_crc_ready = 1'b1;
    @(negedge i_clk);
    i_crc_ready = 1'b0;
    check("idle_valid", o_crc_valid, 0);
    check("idle_busy", o_busy, 0);
    check("idle_crc_hold", o_crc, c);
    check("idle_count_hold", o_count, n);
    crc_out = c;
  endtask

  initial begin
    logic [WPOLY-2:0] r;
    logic [WPOLY-2:0] c;
    int n;
    bit lst;

    i_rst_n = 1'b0; i_start = 1'b0; i_poly = '0; i_seed = '0; i_abort = 1'b0;
    i_data = '0; i_valid = 1'b0; i_last = 1'b0; i_crc_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_ready, 0);
    check("rst_crc", o_crc, 0);
    check("rst_valid", o_crc_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    frame_w[0] = 4'b0001;
    run_frame(2'b00, 1, 1'b1, 0, 0, 5, r);
    check("single_crc", r, 2'b11);
    $display("txn single: crc=%b", r);

    frame_w[0] = 4'b0001; frame_w[1] = 4'b0010; frame_w[2] = 4'b0011; frame_w[3] = 4'b1000;
    run_frame(2'b00, 4, 1'b1, 0, 0, 0, r);
    check("chain_crc_s0", r, 2'b00);
    $display("txn chain seed0: crc=%b", r);
    run_frame(2'b01, 4, 1'b1, 0, 0, 1, r);
    check("chain_crc_s1", r, 2'b01);
    $display("txn chain seed1: crc=%b", r);
    run_frame(2'b00, 4, 1'b1, 2, 2, 0, r);
    check("gap_crc", r, 2'b00);
    $display("txn gaps: crc=%b", r);

    for (int k = 0; k < MAX_WORDS; k++) frame_w[k] = 4'b0001;
    run_frame(2'b00, MAX_WORDS, 1'b0, 0, 0, 0, r);
    check("over_crc", r, 2'b00);
    $display("txn overlength: crc=%b", r);

    // Abort after two words: third word must not be taken.
    do_start(2'b00);
    for (int k = 0; k < 2; k++) begin
      i_valid = 1'b1; i_data = 4'b0001; i_last = 1'b0;
      @(negedge i_clk);
    end
    i_abort = 1'b1; i_data = 4'b0010;
    #1;
    check("abort_ready", o_ready, 0);
    @(negedge i_clk);
    i_abort = 1'b0; i_valid = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_valid", o_crc_valid, 0);
    check("abort_count", o_count, 2);
    check("abort_err", o_err, 0);
    repeat (2) begin
      @(negedge i_clk);
      check("abort_no_valid", o_crc_valid, 0);
    end
    $display("txn abort: count=%0d", o_count);

    // Abort together with start in IDLE suppresses the start.
    i_start = 1'b1; i_abort = 1'b1; i_seed = 2'b10;
    @(negedge i_clk);
    i_start = 1'b0; i_abort = 1'b0;
    check("idle_abort_start", o_busy, 0);
    $display("txn idle abort+start: busy=%0d", o_busy);

    // i_start during RUN must not re-seed or clear the count.
    do_start(2'b00);
    i_valid = 1'b1; i_data = 4'b0001;
    @(negedge i_clk);
    i_valid = 1'b0; i_start = 1'b1; i_seed = 2'b10;
    @(negedge i_clk);
    i_start = 1'b0;
    check("run_start_count", o_count, 1);
    check("run_start_busy", o_busy, 1);
    i_valid = 1'b1; i_data = 4'b0010; i_last = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0; i_last = 1'b0;
    c = ref_step(4'b0010, ref_step(4'b0001, 2'b00, 3'b111), 3'b111);
    check("run_start_crc", o_crc, c);
    check("run_start_cnt2", o_count, 2);
    i_crc_ready = 1'b1;
    @(negedge i_clk);
    i_crc_ready = 1'b0;
    $display("txn start-in-run: crc=%b", o_crc);

    // Asynchronous reset mid-frame.
    do_start(2'b01);
    i_valid = 1'b1; i_data = 4'b0011;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("mrst_busy", o_busy, 0);
    check("mrst_ready", o_ready, 0);
    check("mrst_crc", o_crc, 0);
    check("mrst_count", o_count, 0);
    check("mrst_valid", o_crc_valid, 0);
    check("mrst_err", o_err, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    $display("txn mid-frame reset");

    for (int f = 0; f < 40; f++) begin
      lst = ($urandom_range(7, 0) != 0);
      n = lst ? int'($urandom_range(MAX_WORDS, 1)) : MAX_WORDS;
      for (int k = 0; k < MAX_WORDS; k++) frame_w[k] = 4'($urandom);
      c = 2'($urandom);
      run_frame(c, n, lst, 0, 2, int'($urandom_range(2, 0)), r);
      $display("txn rand %0d: seed=%b n=%0d last=%0d crc=%b", f, c, n, lst, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_frame_ctrl.md
# crc_frame_ctrl

Sequencing controller for the team's combinational CRC step datapath: it accepts a frame of WCODE-bit words over a valid/ready stream and chains one CRC step per accepted word through a running remainder register. It returns the final remainder over a result handshake and enforces a maximum frame length. It sits between the SPI execution unit's word stream and the CRC check logic, instantiating the CRC step datapath internally.

## Interface
Parameters:
- WCODE, 4, data word width (bits per CRC step)
- WPOLY, 3, polynomial width; remainder width is WPOLY-1
- MAX_WORDS, 16, maximum words per frame (≥1)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  frame start pulse, honoured only in IDLE
- i_poly  in  WPOLY  generator polynomial, latched at start
- i_seed  in  WPOLY-1  initial remainder, latched at start
- i_abort  in  1  cancel current frame
- i_data  in  WCODE  data word
- i_valid  in  1  i_data valid
- i_last  in  1  qualifies final word of frame (sampled with i_valid)
- o_ready  out  1  controller accepts word this cycle
- o_crc  out  WPOLY-1  final remainder
- o_crc_valid  out  1  o_crc valid
- i_crc_ready  in  1  consumer takes o_crc
- o_count  out  $clog2(MAX_WORDS+1)  words accepted in current/last frame
- o_busy  out  1  state ≠ IDLE
- o_err  out  1  frame hit MAX_WORDS without i_last

## Operation
- Step function step(d,c,g): t={d,c}; p={g,{WCODE-1{0}}}; for i=WCODE-1 down to 0: if d[i] then t^=p; p>>=1; result t[WPOLY-2:0]. Decisions use original d bits, not updated t. The controller does not alter this arithmetic; it only sequences it.
- Registers: state, poly_r, crc_r, count, err.
- IDLE: o_ready=0, o_crc_valid=0. On i_start: poly_r←i_poly, crc_r←i_seed, count←0, err←0, go RUN.
- RUN: o_ready=1. On i_valid&o_ready: crc_r←step(i_data,crc_r,poly_r), count←count+1.
  - If i_last: go DONE.
  - Else if count+1==MAX_WORDS: err←1, go DONE (frame truncated, CRC of accepted words reported).
  - Else stay in RUN.
  - No i_valid: hold all state.
- DONE: o_crc_valid=1, o_crc=crc_r, o_ready=0. On i_crc_ready go IDLE. o_crc and o_count hold until the next i_start.
- i_abort in RUN or DONE: go IDLE next edge, no o_crc_valid produced, the word presented in that cycle is not accepted (o_ready forced 0 in that cycle), err unchanged. i_abort in IDLE: no effect, and i_start is ignored in that cycle.
- i_start outside IDLE: ignored.
- o_busy=(state≠IDLE). o_err=err, sticky until next accepted i_start.
- o_ready, o_crc_valid, o_busy decode combinationally from state (and i_abort for o_ready). No combinational path from i_valid to o_ready.

## Timing
- Reset: state=IDLE, crc_r=0, poly_r=0, count=0, err=0. Outputs: o_ready=0, o_crc=0, o_crc_valid=0, o_count=0, o_busy=0, o_err=0.
- Start→RUN: o_ready high the cycle after the i_start edge. A word presented with i_start is not accepted.
- Throughput: one word per cycle in RUN.
- Latency: o_crc_valid is asserted the cycle after the edge that accepts the last word. It stays high until the cycle i_crc_ready is sampled high, then drops next cycle.
- New frame: i_start is accepted at the earliest in the cycle after returning to IDLE, so the minimum frame period is N+2 cycles for N words.
- Asynchronous reset mid-frame: immediate return to reset values, partial CRC discarded.

## Test plan
WCODE=4, WPOLY=3, i_poly=3'b111 throughout. For these values step(d,c)=c^(d[0]?2'b11:0)^(d[1]?2'b10:0).
- Single word: start with seed 2'b00; send 4'b0001 with i_last -> o_crc_valid high one cycle later with o_crc=2'b11, o_count=1, o_err=0. Holding i_crc_ready=0 for 5 cycles -> o_crc stable throughout.
- Chained frame: seed 2'b00; send words 0001, 0010, 0011, 1000 (last) back-to-back -> remainders 11, 01, 00, 00; o_crc=2'b00, o_count=4. Repeat with seed 2'b01 -> o_crc=2'b01.
- Backpressure gaps: same 4-word frame with i_valid low for 2 cycles between words -> identical o_crc, o_count=4, and no word accepted while i_valid is low.
- Overlength: MAX_WORDS=16; send 16 words of 4'b0001 with i_last never set -> DONE after the 16th word, o_err=1, o_count=16, o_crc=2'b00 (16 toggles of 11). Next i_start clears o_err.
- Abort and reset: abort after 2 words -> IDLE next cycle, o_crc_valid never asserted, o_busy=0. Separately, assert i_rst_n=0 mid-frame -> all outputs zero immediately. i_start during RUN is ignored (count and crc_r unchanged).
